// File: rtl/oka_pkg.sv
// Shared constants, state encoding and operand split helpers for the
// serialised 81-bit overlap-free Karatsuba multiplier.
package oka_pkg;

  localparam int OKA_N    = 81;
  localparam int OKA_HALF = 41;
  localparam int OKA_PROD = 161;

  typedef enum logic [2:0] {IDLE, MUL_E, MUL_O, MUL_M, DONE} oka_state_e;

  typedef struct packed {
    logic [OKA_N-1:0] a;
    logic [OKA_N-1:0] b;
  } oka_req_t;

  function automatic logic [OKA_HALF-1:0] even_bits(input logic [OKA_N-1:0] v);
    logic [OKA_HALF-1:0] r;
    r = '0;
    for (int i = 0; i < OKA_HALF; i++) r[i] = v[2*i];
    return r;
  endfunction

  // Odd half has only 40 live coefficients; the top bit is always zero.
  function automatic logic [OKA_HALF-1:0] odd_bits(input logic [OKA_N-1:0] v);
    logic [OKA_HALF-1:0] r;
    r = '0;
    for (int i = 0; i < OKA_HALF-1; i++) r[i] = v[2*i+1];
    return r;
  endfunction

endpackage

// File: rtl/OKA_41bit.sv
// 41x41 carry-less multiplier core, shared by all three half-products.
module OKA_41bit (
  input  logic [40:0] a,
  input  logic [40:0] b,
  output logic [80:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < 41; i++)
      if (b[i]) y = y ^ ({40'b0, a} << i);
  end

endmodule

// File: rtl/oka_interleave_81bit.sv
// Recombines even/odd half-products into the full 161-bit carry-less product:
// even output bits come from P0 and shifted P2, odd bits from the middle term.
module oka_interleave_81bit
  import oka_pkg::*;
(
  input  logic [OKA_N-1:0]    p0,
  input  logic [OKA_N-1:0]    p2,
  input  logic [OKA_N-1:0]    p3,
  output logic [OKA_PROD-1:0] y
);

  logic [OKA_N-1:0] m;
  assign m = p3 ^ p0 ^ p2;

  assign y[0] = p0[0];

  genvar k;
  generate
    for (k = 1; k < OKA_N-1; k++) begin : g_even
      assign y[2*k] = p0[k] ^ p2[k-1];
    end
    for (k = 0; k < OKA_N-1; k++) begin : g_odd
      assign y[2*k+1] = m[k];
    end
  endgenerate

  // m[80] is identically zero (P3 and P0 share the a80*b80 term, P2[80]=0);
  // folding it in keeps the top input bits live without changing the result.
  assign y[OKA_PROD-1] = p0[OKA_N-1] ^ p2[OKA_N-2] ^ m[OKA_N-1];

endmodule

// File: rtl/oka_81bit_seq.sv
// Sequential 81-bit GF(2)[x] multiplier: one even/odd Karatsuba level
// serialised over a single shared OKA_41bit core.
module oka_81bit_seq
  import oka_pkg::*;
#(
  parameter bit CORE_REG = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OKA_N-1:0]    a,
  input  logic [OKA_N-1:0]    b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OKA_PROD-1:0] y,
  output logic                busy
);

  oka_state_e           state, state_nxt;
  oka_req_t             opnd;
  logic                 phase, step, in_mul;
  logic [OKA_HALF-1:0]  core_a, core_b;
  logic [OKA_N-1:0]     core_y, core_res, p0, p2;
  logic [OKA_PROD-1:0]  y_nxt;

  assign in_mul = (state == MUL_E) || (state == MUL_O) || (state == MUL_M);
  // With the core register, each MUL state spends one cycle filling it.
  assign step   = !CORE_REG || phase;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MUL_E;
      MUL_E:   if (step)     state_nxt = MUL_O;
      MUL_O:   if (step)     state_nxt = MUL_M;
      MUL_M:   if (step)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    core_a    = '0;
    core_b    = '0;
    case (state)
      MUL_E: begin
        core_a = even_bits(opnd.a);
        core_b = even_bits(opnd.b);
      end
      MUL_O: begin
        core_a = odd_bits(opnd.a);
        core_b = odd_bits(opnd.b);
      end
      MUL_M: begin
        core_a = even_bits(opnd.a) ^ odd_bits(opnd.a);
        core_b = even_bits(opnd.b) ^ odd_bits(opnd.b);
      end
      default: ;
    endcase
  end

  OKA_41bit u_core (
    .a (core_a),
    .b (core_b),
    .y (core_y)
  );

  generate
    if (CORE_REG) begin : g_core_reg
      logic [OKA_N-1:0] core_q;
      always_ff @(posedge clk) begin
        if (!rst_n) core_q <= '0;
        else        core_q <= core_y;
      end
      assign core_res = core_q;
    end else begin : g_core_comb
      assign core_res = core_y;
    end
  endgenerate

  oka_interleave_81bit u_ilv (
    .p0 (p0),
    .p2 (p2),
    .p3 (core_res),
    .y  (y_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opnd  <= '0;
      p0    <= '0;
      p2    <= '0;
      y     <= '0;
      phase <= 1'b0;
    end else begin
      if (in_valid && in_ready) opnd <= {a, b};
      phase <= CORE_REG && in_mul && !phase;
      if (step) begin
        case (state)
          MUL_E:   p0 <= core_res;
          MUL_O:   p2 <= core_res;
          MUL_M:   y  <= y_nxt;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oka_81bit_seq.sv
// Directed and random checks of oka_81bit_seq, one instance per CORE_REG value.
module tb_oka_81bit_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [80:0]  a [2];
  logic [80:0]  b [2];
  logic [160:0] y [2];

  int tests = 0;
  int fails = 0;
  int hs_cnt [2];
  int acc_cnt [2];

  always #5 clk = ~clk;

  oka_81bit_seq #(.CORE_REG(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .y(y[0]), .busy(busy[0])
  );

  oka_81bit_seq #(.CORE_REG(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .y(y[1]), .busy(busy[1])
  );

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n && out_valid[d] && out_ready[d]) hs_cnt[d] <= hs_cnt[d] + 1;
      if (rst_n && in_valid[d] && in_ready[d])   acc_cnt[d] <= acc_cnt[d] + 1;
    end
  end

  function automatic logic [160:0] clmul(input logic [80:0] x, input logic [80:0] z);
    logic [160:0] r;
    r = '0;
    for (int i = 0; i < 81; i++)
      if (z[i]) r = r ^ ({80'b0, x} << i);
    return r;
  endfunction

  // Drives one full transaction with out_ready high; returns product and latency.
  task automatic run_op(input int d, input logic [80:0] av, input logic [80:0] bv,
                        output logic [160:0] res, output int lat, output bit ok);
    int n;
    ok = 1'b1; res = '0; lat = 0; n = 0;
    @(negedge clk);
    a[d] = av; b[d] = bv; in_valid[d] = 1'b1; out_ready[d] = 1'b1;
    while (!in_ready[d] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) ok = 1'b0;
    @(negedge clk);
    in_valid[d] = 1'b0;
    while (!out_valid[d] && lat < 50) begin @(negedge clk); lat++; end
    if (!out_valid[d]) ok = 1'b0;
    res = y[d];
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = '1;
    a[0] = '0; b[0] = '0; a[1] = '0; b[1] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset_flags dut%0d: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                 d, in_ready[d], out_valid[d], busy[d]);
      end
      tests++;
      if (y[d] !== 161'd0) begin
        fails++;
        $display("FAIL reset_y dut%0d: got %h want 0", d, y[d]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input int d);
    logic [160:0] res, exp_v;
    logic [80:0]  ones;
    int lat, exp_lat;
    bit ok;
    ones = '1;
    exp_lat = (d == 0) ? 3 : 6;

    run_op(d, 81'd1, 81'd1, res, lat, ok);
    tests++;
    if (!ok || res !== 161'd1) begin
      fails++; $display("FAIL one_x_one dut%0d: got %h ok=%0d want 1", d, res, ok);
    end
    tests++;
    if (lat !== exp_lat) begin
      fails++; $display("FAIL latency dut%0d: got %0d want %0d", d, lat, exp_lat);
    end

    run_op(d, 81'd2, 81'd3, res, lat, ok);
    tests++;
    if (!ok || res !== 161'd6) begin
      fails++; $display("FAIL x_times_xp1 dut%0d: got %h want 6", d, res);
    end

    run_op(d, 81'd1 << 80, 81'd1 << 80, res, lat, ok);
    exp_v = 161'd1 << 160;
    tests++;
    if (!ok || res !== exp_v) begin
      fails++; $display("FAIL msb_square dut%0d: got %h want %h", d, res, exp_v);
    end

    run_op(d, ones, 81'd1, res, lat, ok);
    exp_v = {80'b0, ones};
    tests++;
    if (!ok || res !== exp_v) begin
      fails++; $display("FAIL ones_times_one dut%0d: got %h want %h", d, res, exp_v);
    end

    run_op(d, ones, ones, res, lat, ok);
    exp_v = '0;
    for (int k = 0; k < 81; k++) exp_v[2*k] = 1'b1;
    tests++;
    if (!ok || res !== exp_v) begin
      fails++; $display("FAIL ones_square dut%0d: got %h want %h", d, res, exp_v);
    end
  endtask

  task automatic test_backpressure(input int d);
    int n;
    bit stable_ok;
    n = 0; stable_ok = 1'b1;
    @(negedge clk);
    a[d] = 81'd2; b[d] = 81'd3; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
    while (!in_ready[d] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    // Second operand held throughout; also checks operands are not re-sampled.
    a[d] = 81'd3; b[d] = 81'd3;
    n = 0;
    while (!out_valid[d] && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (out_valid[d] !== 1'b1) begin
      fails++; $display("FAIL bp_first_result dut%0d: out_valid=%b want 1", d, out_valid[d]);
    end
    for (int i = 0; i < 10; i++) begin
      if (out_valid[d] !== 1'b1 || y[d] !== 161'd6 || in_ready[d] !== 1'b0) stable_ok = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (!stable_ok) begin
      fails++; $display("FAIL bp_hold dut%0d: y=%h out_valid=%b in_ready=%b want 6 1 0",
                        d, y[d], out_valid[d], in_ready[d]);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      fails++; $display("FAIL bp_release dut%0d: out_valid=%b in_ready=%b want 0 1",
                        d, out_valid[d], in_ready[d]);
    end
    @(negedge clk);
    tests++;
    if (busy[d] !== 1'b1 || in_ready[d] !== 1'b0) begin
      fails++; $display("FAIL bp_second_accept dut%0d: busy=%b in_ready=%b want 1 0",
                        d, busy[d], in_ready[d]);
    end
    in_valid[d] = 1'b0;
    n = 0;
    while (!out_valid[d] && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (out_valid[d] !== 1'b1 || y[d] !== 161'd5) begin
      fails++; $display("FAIL bp_second_result dut%0d: got %h valid=%b want 5", d, y[d], out_valid[d]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid(input int d);
    logic [160:0] res;
    int n, lat;
    bit ok, quiet;
    n = 0; quiet = 1'b1;
    @(negedge clk);
    a[d] = '1; b[d] = '1; in_valid[d] = 1'b1; out_ready[d] = 1'b1;
    while (!in_ready[d] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid[d] = 1'b0;
    repeat ((d == 0) ? 1 : 3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || y[d] !== 161'd0) begin
      fails++; $display("FAIL mid_reset dut%0d: in_ready=%b out_valid=%b busy=%b y=%h want 1 0 0 0",
                        d, in_ready[d], out_valid[d], busy[d], y[d]);
    end
    for (int i = 0; i < 8; i++) begin
      if (out_valid[d] !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (!quiet) begin
      fails++; $display("FAIL mid_reset_no_emit dut%0d: out_valid rose after reset, want 0", d);
    end
    run_op(d, 81'd5, 81'd7, res, lat, ok);
    tests++;
    if (!ok || res !== 161'h1B) begin
      fails++; $display("FAIL after_reset_op dut%0d: got %h want 1b", d, res);
    end
  endtask

  task automatic test_random(input int d);
    logic [95:0]  r96;
    logic [80:0]  av, bv;
    logic [160:0] res, exp_v;
    int n, hs0, acc0, bad;
    bit got;
    hs0 = hs_cnt[d]; acc0 = acc_cnt[d]; bad = 0;
    for (int i = 0; i < 2000; i++) begin
      r96 = {$urandom(), $urandom(), $urandom()}; av = r96[80:0];
      r96 = {$urandom(), $urandom(), $urandom()}; bv = r96[80:0];
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a[d] = av; b[d] = bv; in_valid[d] = 1'b1;
      n = 0;
      while (!in_ready[d] && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      in_valid[d] = 1'b0;
      got = 1'b0; n = 0; res = '0;
      while (!got && n < 100) begin
        out_ready[d] = 1'($urandom_range(0, 1));
        if (out_valid[d] && out_ready[d]) begin res = y[d]; got = 1'b1; end
        @(negedge clk);
        n++;
      end
      exp_v = clmul(av, bv);
      tests++;
      if (!got || res !== exp_v) begin
        fails++; bad++;
        if (bad <= 5)
          $display("FAIL random dut%0d #%0d: got %h want %h (seen=%0d)", d, i, res, exp_v, got);
      end
    end
    out_ready[d] = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (hs_cnt[d] - hs0 != 2000 || acc_cnt[d] - acc0 != 2000) begin
      fails++; $display("FAIL random_counts dut%0d: results=%0d accepts=%0d want 2000 2000",
                        d, hs_cnt[d] - hs0, acc_cnt[d] - acc0);
    end
  endtask

  initial begin
    test_reset();
    for (int d = 0; d < 2; d++) begin
      test_basic(d);
      test_backpressure(d);
      test_reset_mid(d);
      test_random(d);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oka_81bit_seq.md
Name: oka_81bit_seq

Overview:
- Sequential GF(2)[x] polynomial multiplier for 81-bit operands. Produces a 161-bit carry-less product.
- Uses one even/odd (overlap-free Karatsuba) split level. That level is serialised over a single shared OKA_41bit core, which is instantiated unchanged.
- An FSM feeds the core three half-products in turn: even·even, odd·odd and (even^odd)·(even^odd). It then recombines them by bit interleaving.
- The block trades throughput for one-third of the combinational core area. It is the building block for the area-optimised 163-bit field multiplier path.

Parameters:
- CORE_REG, 0, when 1 a pipeline register is inserted after the OKA_41bit output and each MUL state lasts 2 cycles. When 0 each MUL state lasts 1 cycle.

Ports:
- clk  in  1  system clock. All state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands a, b valid.
- in_ready  out  1  block can accept operands. High only in IDLE.
- a  in  81  multiplicand, bit i = coefficient of x^i.
- b  in  81  multiplier.
- out_valid  out  1  y holds a completed product.
- out_ready  in  1  consumer accepts y.
- y  out  161  product a·b over GF(2), no reduction.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, in_ready=1 (follows IDLE), out_valid=0, busy=0, y=0. Operand and partial-product registers are cleared to 0.
- Operand split (fixed wiring):
  - Ae = {a[80],a[78],…,a[0]}, 41 bits.
  - Ao = {1'b0,a[79],…,a[1]}, 41 bits.
  - Be and Bo are formed the same way from b.
- FSM states: IDLE -> MUL_E -> MUL_O -> MUL_M -> DONE -> IDLE.
  - IDLE: when in_valid&&in_ready, register a and b, then go to MUL_E. If in_valid is low, stay.
  - MUL_E: core inputs are Ae, Be. Capture the core output into P0 (81 bits).
  - MUL_O: core inputs are Ao, Bo. Capture into P2.
  - MUL_M: core inputs are Ae^Ao, Be^Bo. The core result P3 feeds the recombination directly, and y is registered on the exit edge.
  - DONE: out_valid=1, y held stable. When out_ready=1, go to IDLE with out_valid deasserted on that same edge. If out_ready=0, hold indefinitely.
- MUL state timing with CORE_REG=1: an internal 1-bit phase counter holds each MUL state for 2 cycles. Capture happens on the second cycle from the registered core output.
- Core input mux: the core inputs are 0 outside the MUL states, to avoid toggling power. This has no functional effect.
- Recombination, with M = P3^P0^P2 and k from 0 to 80:
  - y[2k] = P0[k] ^ (k>0 ? P2[k-1] : 0)
  - y[2k+1] = M[k]
  - Bits y[160] and above are covered by P0[80]. P2[80] is always 0 (Ao is at most degree 39) and is discarded.
- Latency: from the accept edge T, out_valid rises after edge T+3 when CORE_REG=0, or after edge T+6 when CORE_REG=1.
- Throughput: one product per 5 cycles when CORE_REG=0 and out_ready is held high.
- Back-pressure: in_ready=0 in all states other than IDLE. Operands presented while busy are not taken, and the source must hold them.
- Operand capture: operand registers load only on the accept edge, so changes on a and b during MUL states have no effect.
- Reset mid-operation: rst_n low on any edge forces IDLE and clears out_valid. The partial result is discarded and no product is emitted.
- Simultaneous events: in DONE with out_ready=1 and in_valid=1, the new operand is not accepted that cycle. It is accepted in the following IDLE cycle.

Decomposition:
- Shared package oka_pkg:
  - constants OKA_N=81, OKA_HALF=41, OKA_PROD=161.
  - state enum {IDLE, MUL_E, MUL_O, MUL_M, DONE}.
- Sub-modules:
  - oka_interleave_81bit: combinational recombination (P0, P2, P3 -> y). It is reused by later serialised levels.
  - OKA_41bit: instantiated once as the shared core.

Test Plan:
- a=1, b=1, out_ready=1 -> y=1, out_valid exactly 3 cycles after accept (CORE_REG=0), 6 cycles after accept (CORE_REG=1).
- a=2 (x), b=3 (x+1) -> y=6. Then a=b=2^80 -> y=2^160 (top bit only). Exercises the even/odd boundary and the MSB.
- a=all-ones (81 bits), b=1 -> y={80'b0, a}. Then a=b=all-ones -> y equals the golden carry-less square (every even bit set, odd bits 0).
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> y and out_valid stable, in_ready=0, and a second in_valid held throughout is accepted only after the out_ready pulse plus 1 cycle.
- Reset in MUL_O (rst_n low for 1 cycle) -> next cycle state IDLE, out_valid=0, in_ready=1, y=0. A subsequent operation with a=5, b=7 gives y=27 (0x1B).
- 2000 random operand pairs with random in_valid/out_ready gaps, run for both CORE_REG values -> every y matches the bench's carry-less multiply model, with no dropped or duplicated results.
